// File: rtl/monitor_disp_pkg.sv
// Shared types for the monitor display path: digit width, nibble type and digit count.
package monitor_disp_pkg;
  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] nibble_t;

  function automatic int num_digits(input int word_w);
    return word_w / DIGIT_W;
  endfunction
endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus stability counter for an active-low push button.
// press strobes in the cycle the debounced level is about to fall 1->0.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic n_reset,
  input  logic n_btn,
  output logic level,
  output logic press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             settle;

  always_comb begin
    settle  = (sync2_q != level_q) && (cnt_q == CNT_LAST);
    level_d = settle ? sync2_q : level_q;
    if ((sync2_q == level_q) || settle) cnt_d = '0;
    else                                cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= n_btn;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  // settle with level_q high can only mean the synchronized pin is low
  assign press = settle & level_q;
endmodule

// File: rtl/hex_page_selector.sv
// Picks one monitored word per page and registers it as nibbles for the hex digits.
// Pages advance on a debounced button press or the auto-scroll timer; sw_freeze holds everything.
module hex_page_selector
  import monitor_disp_pkg::*;
#(
  parameter int NUM_WORDS       = 8,
  parameter int WORD_W          = 16,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SCROLL_CYCLES   = 50000000
) (
  input  logic                           clk,
  input  logic                           n_reset,
  input  logic [NUM_WORDS*WORD_W-1:0]    words,
  input  logic                           n_btn_next,
  input  logic                           sw_auto,
  input  logic                           sw_freeze,
  output logic [WORD_W-1:0]              nibbles,
  output logic [$clog2(NUM_WORDS)-1:0]   page,
  output logic                           page_tick
);
  localparam int PAGE_W     = $clog2(NUM_WORDS);
  localparam int SCR_W      = $clog2(SCROLL_CYCLES);
  localparam int NUM_DIGITS = num_digits(WORD_W);
  localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(NUM_WORDS - 1);
  localparam logic [SCR_W-1:0]  SCR_LAST  = SCR_W'(SCROLL_CYCLES - 1);

  logic press, unused_btn_level;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_next (
    .clk    (clk),
    .n_reset(n_reset),
    .n_btn  (n_btn_next),
    .level  (unused_btn_level),
    .press  (press)
  );

  logic [SCR_W-1:0]  scr_q, scr_d;
  logic [PAGE_W-1:0] page_q, page_d;
  logic              tick_q;
  logic              scroll_ev, advance;
  logic [WORD_W-1:0] sel_word;
  nibble_t [NUM_DIGITS-1:0] nib_q;

  always_comb begin
    scroll_ev = sw_auto & ~sw_freeze & (scr_q == SCR_LAST);
    advance   = (press | scroll_ev) & ~sw_freeze;
    // a manual step restarts the auto-scroll period
    if (!sw_auto)                scr_d = '0;
    else if (sw_freeze)          scr_d = scr_q;
    else if (press || scroll_ev) scr_d = '0;
    else                         scr_d = scr_q + SCR_W'(1);
    page_d = page_q;
    if (advance) page_d = (page_q == PAGE_LAST) ? '0 : page_q + PAGE_W'(1);
  end

  // unreachable page codes fall back to word 0
  always_comb begin
    sel_word = words[WORD_W-1:0];
    for (int k = 1; k < NUM_WORDS; k++)
      if (page_q == PAGE_W'(k)) sel_word = words[k*WORD_W +: WORD_W];
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      scr_q  <= '0;
      page_q <= '0;
      tick_q <= 1'b0;
    end else begin
      scr_q  <= scr_d;
      page_q <= page_d;
      tick_q <= advance;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      nib_q <= '0;
    end else if (!sw_freeze) begin
      for (int i = 0; i < NUM_DIGITS; i++)
        nib_q[i] <= sel_word[i*DIGIT_W +: DIGIT_W];
    end
  end

  assign nibbles   = nib_q;
  assign page      = page_q;
  assign page_tick = tick_q;
endmodule

// File: doc/hex_page_selector.md
Name: hex_page_selector

Overview:
- Upstream feeder for the four per-digit hex decoders on the monitor display.
- Selects one of NUM_WORDS monitored CPU words (PC, IR, registers, etc.) and presents it as registered 4-bit nibbles, one nibble per digit.
- The page advances on a debounced push-button press or on an auto-scroll timer, and can be frozen for reading.
- Sits between the CPU monitor taps and the hex decoder instances.

Parameters:
- NUM_WORDS, 8: number of monitored words (≥2).
- WORD_W, 16: bits per word; fixed multiple of 4, giving WORD_W/4 digits.
- DEBOUNCE_CYCLES, 500000: cycles the synchronized button must stay stable before it is accepted (≥2).
- SCROLL_CYCLES, 50000000: auto-scroll period in cycles (≥2).

Ports:
- clk  in  1  system clock.
- n_reset  in  1  asynchronous, active-low reset.
- words  in  NUM_WORDS*WORD_W  flattened monitor words; word k = bits [k*WORD_W +: WORD_W].
- n_btn_next  in  1  raw push button, active-low, asynchronous to clk.
- sw_auto  in  1  1 = auto-scroll enabled.
- sw_freeze  in  1  1 = hold the display and page.
- nibbles  out  WORD_W  displayed word; nibble i = bits [4i+3:4i] and drives hex decoder i.
- page  out  clog2(NUM_WORDS)  index of the selected word.
- page_tick  out  1  one-cycle pulse, asserted in the same cycle page takes its new value.

Behaviour:
- One clock domain, clk. Asynchronous, active-low reset n_reset.
- Reset values:
  - nibbles = 0, page = 0, page_tick = 0.
  - Both synchronizer flops = 1; debounced level = 1 (released).
  - Debounce counter = 0; scroll counter = 0.
- Reset asserted mid-operation clears everything to these values immediately. No press is generated after reset release while the button is held, because the press requires a 1→0 change of the debounced level.
- Button synchronizer: 2 flops.
- Debounce:
  - The counter clears whenever the synchronized value equals the debounced level.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the debounced level takes the synchronized value and the counter clears.
  - press = debounced level goes 1→0; this is a single-cycle internal event.
  - Minimum press latency from a clean pin edge: 2 + DEBOUNCE_CYCLES cycles.
- Scroll timer:
  - Counts only while sw_auto=1 and sw_freeze=0.
  - Cleared (not held) while sw_auto=0.
  - Held at its value while sw_freeze=1.
  - At SCROLL_CYCLES-1 it generates scroll_ev and wraps to 0.
- Advance = (press | scroll_ev) & ~sw_freeze.
  - press and scroll_ev in the same cycle advance by exactly one page.
  - Any press clears the scroll counter, so auto-scroll restarts a full period after a manual step.
- page update: page <= (page == NUM_WORDS-1) ? 0 : page+1 on advance. page_tick = registered advance.
- Press while frozen is discarded, not queued. The debounced level still tracks the pin.
- nibbles:
  - When sw_freeze=0: nibbles <= word[page] every cycle, so words-to-nibbles latency is 1 cycle.
  - After an advance, the new word appears on nibbles one cycle after page/page_tick.
  - When sw_freeze=1: nibbles holds its value.
- Out-of-range page values are unreachable; the select logic defaults to word 0.
- No combinational path from any input to any output.

Decomposition:
- Package monitor_disp_pkg:
  - DIGIT_W = 4.
  - Function num_digits(WORD_W).
  - Typedef nibble_t (logic [3:0]), shared with the hex decoder's num input.
- Sub-module button_debouncer:
  - Contains the synchronizer, debounce counter and falling-edge press pulse.
  - Parameter DEBOUNCE_CYCLES.
  - Ports clk, n_reset, n_btn, level, press.
  - Reused for other monitor buttons.
- Top module: scroll timer, page counter, word mux, output register.

Test Plan (NUM_WORDS=3, WORD_W=16, DEBOUNCE_CYCLES=4, SCROLL_CYCLES=10; words = {0xCCCC, 0xBBBB, 0xAAAA} for k = 2,1,0):
- Reset, then release:
  - nibbles=0, page=0, page_tick=0 during reset.
  - One cycle after release, nibbles=0xAAAA.
  - Change word0 to 0x1234: nibbles=0x1234 one cycle later.
- Clean press held 20 cycles, sw_auto=0:
  - Exactly one page_tick, about 6 cycles after the pin falls.
  - page=1; nibbles=0xBBBB one cycle after that.
  - Release produces no tick.
- Bounce pin 1/0 every 2 cycles for 12 cycles, then hold low: exactly one advance, and only after the pin is stable for 4 cycles.
- Three clean presses from page=0: page sequence 1, 2, 0 (wrap); nibbles 0xBBBB, 0xCCCC, 0xAAAA.
- sw_auto=1, no press:
  - page_tick every 10 cycles; page 0→1→2→0.
  - Drop sw_auto at count 7, raise it again: next tick a full 10 cycles later.
- sw_freeze=1:
  - Change word0 to 0xFFFF: nibbles unchanged.
  - Press and auto ticks are ignored; page is constant.
  - Deassert sw_freeze: nibbles=0xFFFF next cycle; scroll resumes from its held count.
  - Press coinciding with scroll_ev after unfreeze: single advance.
